// File: rtl/uart_pkg.sv
// Shared types and constants for the UART Tx buffer slice.
`default_nettype none

package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LAUNCH    = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } launch_state_e;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

endpackage

`default_nettype wire

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with occupancy count, synchronous flush and sticky overflow flag.
`default_nettype none

module uart_sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_en,
  input  logic [DATA_WIDTH-1:0]         wr_data,
  input  logic                          rd_en,
  input  logic                          flush,
  input  logic                          clr_overflow,
  output logic [DATA_WIDTH-1:0]         rd_data,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          overflow
);

  localparam int             AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]    DEPTH_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW-1:0]  PTR_ONE = AW'(1);
  localparam logic [AW:0]    CNT_ONE = (AW+1)'(1);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [AW:0]           count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  push, pop, drop;

  assign full    = (count_q == DEPTH_C);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign overflow = overflow_q;
  assign rd_data = mem_q[rd_ptr_q];

  // A pop frees a slot in the same cycle, so a write against a full FIFO is still accepted.
  assign pop  = rd_en && !empty && !flush;
  assign push = wr_en && !flush && (!full || pop);
  assign drop = wr_en && !flush && full && !pop;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
    if (drop)              overflow_d = 1'b1;
    else if (clr_overflow) overflow_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx_buffer.sv
// Byte FIFO feeding the UART Tx control unit: launches one frame at a time and
// holds the launched byte and its parity stable until the frame completes.
`default_nettype none

module uart_tx_buffer
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          UCLK,
  input  logic                          reset,
  input  logic                          wr_en,
  input  logic [DATA_WIDTH-1:0]         wr_data,
  input  logic                          flush,
  input  logic                          clr_overflow,
  input  logic                          tx_enable,
  input  logic                          parity_type,
  input  logic                          busy,
  output logic                          data_valid,
  output logic [DATA_WIDTH-1:0]         tx_data,
  output logic                          parity_bit,
  output logic                          fifo_full,
  output logic                          fifo_empty,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  launch_state_e         state_q, state_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic [DATA_WIDTH-1:0] fifo_rd_data;
  logic                  launch;

  uart_sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk          (UCLK),
    .rst_n        (reset),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .rd_en        (launch),
    .flush        (flush),
    .clr_overflow (clr_overflow),
    .rd_data      (fifo_rd_data),
    .full         (fifo_full),
    .empty        (fifo_empty),
    .count        (fifo_count),
    .overflow     (overflow)
  );

  // The pop happens on the IDLE->LAUNCH edge, so data_valid and the new byte appear together.
  always_comb begin
    state_d    = state_q;
    launch     = 1'b0;
    data_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty && tx_enable && !busy && !flush) begin
          launch  = 1'b1;
          state_d = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        data_valid = 1'b1;
        state_d    = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (busy) state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (!busy) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign tx_data_d = launch ? fifo_rd_data : tx_data_q;

  always_ff @(posedge UCLK or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      tx_data_q <= '0;
    end else begin
      state_q   <= state_d;
      tx_data_q <= tx_data_d;
    end
  end

  assign tx_data = tx_data_q;

  always_comb begin
    case (parity_type)
      PARITY_EVEN: parity_bit = ^tx_data_q;
      PARITY_ODD:  parity_bit = ~^tx_data_q;
      default:     parity_bit = ^tx_data_q;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_buffer.sv
// Directed bench for uart_tx_buffer paired with a simple Tx control unit model.
`default_nettype none

module tb_uart_tx_buffer;

  localparam int FRAME = 8;

  logic       UCLK = 1'b0;
  logic       reset;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       flush = 1'b0;
  logic       clr_overflow = 1'b0;
  logic       tx_enable = 1'b0;
  logic       parity_type = 1'b0;
  logic       busy;
  logic       data_valid;
  logic [7:0] tx_data;
  logic       parity_bit;
  logic       fifo_full;
  logic       fifo_empty;
  logic [4:0] fifo_count;
  logic       overflow;

  int n_checks = 0;
  int n_fail   = 0;
  int cnt;

  always #5 UCLK = ~UCLK;

  uart_tx_buffer #(.DATA_WIDTH(8), .FIFO_DEPTH(16)) dut (
    .UCLK         (UCLK),
    .reset        (reset),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .flush        (flush),
    .clr_overflow (clr_overflow),
    .tx_enable    (tx_enable),
    .parity_type  (parity_type),
    .busy         (busy),
    .data_valid   (data_valid),
    .tx_data      (tx_data),
    .parity_bit   (parity_bit),
    .fifo_full    (fifo_full),
    .fifo_empty   (fifo_empty),
    .fifo_count   (fifo_count),
    .overflow     (overflow)
  );

  // Control unit model: samples data_valid, then holds busy for FRAME cycles.
  always @(posedge UCLK or negedge reset) begin
    if (!reset) begin
      busy <= 1'b0;
      cnt  <= 0;
    end else if (data_valid) begin
      busy <= 1'b1;
      cnt  <= FRAME;
    end else if (busy) begin
      cnt <= cnt - 1;
      if (cnt == 1) busy <= 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge UCLK);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((busy || data_valid) && n < 200) begin
      tick();
      n++;
    end
    check({tag, " idle timeout"}, 32'(n < 200), 32'd1);
    tick();
    tick();
  endtask

  initial begin
    int         pulses;
    int         dbl;
    int         early;
    int         unstable;
    int         n;
    logic       prev_busy;
    logic       prev_dv;
    logic [7:0] held;
    logic [7:0] got [3];

    reset = 1'b1;
    #1 reset = 1'b0;
    repeat (3) tick();

    // 1. reset values, single byte latency and parity
    check("rst empty",    fifo_empty, 1);
    check("rst full",     fifo_full, 0);
    check("rst count",    fifo_count, 0);
    check("rst overflow", overflow, 0);
    check("rst dv",       data_valid, 0);
    check("rst tx_data",  tx_data, 0);
    reset = 1'b1;
    tx_enable = 1'b1;
    tick();
    push(8'hA5);
    check("t1 count N",   fifo_count, 1);
    check("t1 dv N",      data_valid, 0);
    tick();
    check("t1 dv N+1",    data_valid, 1);
    check("t1 tx_data",   tx_data, 8'hA5);
    check("t1 par even",  parity_bit, 0);
    check("t1 count pop", fifo_count, 0);
    parity_type = 1'b1;
    #1;
    check("t1 par odd",   parity_bit, 1);
    parity_type = 1'b0;
    tick();
    check("t1 dv N+2",    data_valid, 0);
    check("t1 busy",      busy, 1);
    wait_idle("t1");

    // 2. three back-to-back frames
    pulses = 0; dbl = 0; early = 0; unstable = 0;
    prev_busy = busy; prev_dv = data_valid; held = tx_data;
    got[0] = 8'h00; got[1] = 8'h00; got[2] = 8'h00;
    for (int c = 0; c < 100; c++) begin
      wr_en   = (c < 3);
      wr_data = 8'(c + 1);
      tick();
      if (data_valid) begin
        if (pulses < 3) got[pulses] = tx_data;
        pulses++;
        if (prev_dv)   dbl++;
        if (prev_busy) early++;
        held = tx_data;
      end
      if (busy && tx_data != held) unstable++;
      prev_busy = busy;
      prev_dv   = data_valid;
    end
    wr_en = 1'b0;
    check("t2 pulses",   pulses, 3);
    check("t2 byte0",    got[0], 8'h01);
    check("t2 byte1",    got[1], 8'h02);
    check("t2 byte2",    got[2], 8'h03);
    check("t2 double",   dbl, 0);
    check("t2 early",    early, 0);
    check("t2 unstable", unstable, 0);
    wait_idle("t2");

    // 3. fill with launches disabled, overflow and clear
    tx_enable = 1'b0;
    for (int i = 0; i < 16; i++) push(8'(8'h10 + i));
    check("t3 count16",  fifo_count, 16);
    check("t3 full",     fifo_full, 1);
    check("t3 ovf pre",  overflow, 0);
    push(8'hFF);
    check("t3 count drop", fifo_count, 16);
    check("t3 ovf set",  overflow, 1);
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    check("t3 ovf clr",  overflow, 0);
    wr_en = 1'b1; wr_data = 8'hFF; clr_overflow = 1'b1;
    tick();
    wr_en = 1'b0; clr_overflow = 1'b0;
    check("t3 set wins", overflow, 1);
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    check("t3 ovf clr2", overflow, 0);

    // 4. write in the pop cycle of a full FIFO
    tx_enable = 1'b1; wr_en = 1'b1; wr_data = 8'h77;
    tick();
    wr_en = 1'b0;
    tx_enable = 1'b0;
    check("t4 count",    fifo_count, 16);
    check("t4 ovf",      overflow, 0);
    check("t4 dv",       data_valid, 1);
    check("t4 tx_data",  tx_data, 8'h10);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t4 flush cnt", fifo_count, 0);
    check("t4 flush emp", fifo_empty, 1);
    wait_idle("t4");

    // 5. flush with a frame in flight and five entries queued
    tx_enable = 1'b1;
    for (int i = 0; i < 6; i++) push(8'(8'h40 + i));
    check("t5 busy",     busy, 1);
    check("t5 count5",   fifo_count, 5);
    flush = 1'b1; wr_en = 1'b1; wr_data = 8'hEE;
    tick();
    flush = 1'b0; wr_en = 1'b0;
    check("t5 count0",   fifo_count, 0);
    check("t5 empty",    fifo_empty, 1);
    check("t5 ovf",      overflow, 0);
    pulses = 0;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (data_valid) pulses++;
    end
    check("t5 no dv",    pulses, 0);
    check("t5 done",     busy, 0);
    check("t5 tx_data",  tx_data, 8'h40);

    // 6. reset while waiting for the frame to finish
    push(8'h3C);
    push(8'h3D);
    n = 0;
    while (!busy && n < 20) begin
      tick();
      n++;
    end
    check("t6 busy wait", 32'(n < 20), 1);
    tick();
    check("t6 count1",   fifo_count, 1);
    #2 reset = 1'b0;
    #1;
    check("t6 rst dv",    data_valid, 0);
    check("t6 rst data",  tx_data, 0);
    check("t6 rst count", fifo_count, 0);
    check("t6 rst empty", fifo_empty, 1);
    check("t6 rst full",  fifo_full, 0);
    check("t6 rst ovf",   overflow, 0);
    tick();
    reset = 1'b1;
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (data_valid) pulses++;
    end
    check("t6 no dv",    pulses, 0);
    push(8'h5A);
    check("t6 dv N",     data_valid, 0);
    tick();
    check("t6 dv N+1",   data_valid, 1);
    check("t6 tx_data",  tx_data, 8'h5A);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
